led_driver: RTL and testbench



---
 rtl/led_driver_if.sv | 23 ++
 rtl/led_driver.sv | 73 +++++++
 tb/tb_led_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/led_driver_if.sv
// LED matrix port bundle: pixel frame buffers and scan enable in, header pins out.
// The driver side (master) supplies the frame buffers and enable; the scanner
// (slave) drives the 36-pin GPIO_1 header.
interface led_driver_if;
  logic [35:0]       GPIO_1;       // [35:32] row, [31:16] green cols, [15:0] red cols
  logic [15:0][15:0] RedPixels;    // [row][col], 1 = red LED on
  logic [15:0][15:0] GrnPixels;    // [row][col], 1 = green LED on
  logic              EnableCount;  // 1 = scan advances, 0 = hold current row

  modport master (
    output RedPixels,
    output GrnPixels,
    output EnableCount,
    input  GPIO_1
  );

  modport slave (
    input  RedPixels,
    input  GrnPixels,
    input  EnableCount,
    output GPIO_1
  );
endinterface

// File: rtl/led_driver.sv
// 16x16 red/green LED matrix row scanner.
// One row is displayed per 2**FREQDIV clocks; rows 0..15 repeat continuously.
// Optional anti-ghosting blanking is enabled by defining LEDDRIVER_BLANK_EN:
// the column fields are forced dark during the first quarter of each row period
// while the row field keeps being driven.
module led_driver #(
  parameter int FREQDIV = 14  // log2 of clocks per row period, 2..24
) (
  led_driver_if.slave led,
  input  logic        clock,
  input  logic        reset
);

  localparam logic [FREQDIV-1:0] DIV_LAST = '1;
  localparam logic [FREQDIV-1:0] DIV_ONE  = {{(FREQDIV-1){1'b0}}, 1'b1};

  logic [FREQDIV-1:0] div_reg, div_next;
  logic [3:0]         row_reg, row_next;
  logic [35:0]        gpio_reg, gpio_next;

  logic               row_tick;
  logic               blank;
  logic [15:0]        red_row, grn_row;
  logic [15:0]        red_cols, grn_cols;

  // Current row's pixel words, selected from the packed frame buffers.
  assign red_row = led.RedPixels[row_reg];
  assign grn_row = led.GrnPixels[row_reg];

`ifdef LEDDRIVER_BLANK_EN
  // Columns dark while the top two divider bits are zero (first quarter of the row period).
  assign blank = (div_reg[FREQDIV-1 -: 2] == 2'b00);
`else
  assign blank = 1'b0;
`endif

  // Per-column gating: column bit c follows pixel bit c unless blanked.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_col
      assign red_cols[gi] = red_row[gi] & ~blank;
      assign grn_cols[gi] = grn_row[gi] & ~blank;
    end
  endgenerate

  // Next-state: free-running divider, row advance on divider wrap when enabled,
  // header image rebuilt from the current row every clock.
  always_comb begin
    div_next  = div_reg + DIV_ONE;
    row_tick  = (div_reg == DIV_LAST) && led.EnableCount;
    row_next  = row_reg;
    if (row_tick) begin
      row_next = row_reg + 4'd1;  // 15 wraps to 0 naturally
    end
    gpio_next = {row_reg, grn_cols, red_cols};
  end

  // State registers; reset returns to row 0 with all columns dark.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_reg  <= '0;
      row_reg  <= 4'd0;
      gpio_reg <= 36'h0;
    end else begin
      div_reg  <= div_next;
      row_reg  <= row_next;
      gpio_reg <= gpio_next;
    end
  end

  assign led.GPIO_1 = gpio_reg;

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver with FREQDIV=2 (4 clocks per row).
// Edge counter n counts rising edges since the last reset release; the row shown
// after edge n is (n-1)/4 and, with blanking, edges where (n-1)%4==0 show dark columns.
module tb_led_driver;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   n;

  led_driver_if led();

  led_driver #(.FREQDIV(2)) dut (
    .led   (led.slave),
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    n++;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
    total++;
    assert (obs === exp_v)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    $display("check %s n=%0d observed=%h expected=%h", tag, n, obs, exp_v);
  endtask

  // Apply blanking to an expected header image for edge n when the feature is built in.
  function automatic logic [35:0] cols_at(input int edge_n, input logic [35:0] v);
    logic [35:0] r;
    r = v;
`ifdef LEDDRIVER_BLANK_EN
    if (((edge_n - 1) % 4) == 0) r = {v[35:32], 32'h0};
`endif
    return r;
  endfunction

  initial begin
    logic [3:0]  exp_row;
    logic [15:0] one_hot;
    total = 0;
    bad   = 0;
    n     = 0;

    // Power-up: known state, all red on so the header is visibly non-zero.
    reset           = 1'b1;
    led.EnableCount = 1'b1;
    led.RedPixels   = '1;
    led.GrnPixels   = '0;
    #12;
    reset = 1'b0;
    n     = 0;
    repeat (6) tick();
    chk("pre_reset_row1", led.GPIO_1, 36'h1_0000_FFFF);

    // 1. Asynchronous reset mid-clock clears the header immediately.
    #2 reset = 1'b1;
    #1 chk("reset_async", led.GPIO_1, 36'h0);
    led.RedPixels    = '0;
    led.RedPixels[0] = 16'h8001;
    #2 reset = 1'b0;
    n = 0;
    tick();
    chk("reset_first", led.GPIO_1, cols_at(n, 36'h0_0000_8001));

    // 2. Scan order with one-hot red per row, across a full frame and the wrap to row 0.
    for (int r = 0; r < 16; r++) led.RedPixels[r] = 16'h1 << r;
    while (n < 70) begin
      tick();
      exp_row = 4'((n - 1) / 4);
      one_hot = 16'h1 << exp_row;
      chk("scan", led.GPIO_1, cols_at(n, {exp_row, 16'h0, one_hot}));
    end

    // 3. Reset mid-scan, then hold at row 5 for 40 clocks and re-enable.
    #2 reset = 1'b1;
    #1 chk("reset_midscan", led.GPIO_1, 36'h0);
    #2 reset = 1'b0;
    n = 0;
    while (n < 21) begin
      tick();
      chk("row_after_reset", {32'h0, led.GPIO_1[35:32]}, {32'h0, 4'((n - 1) / 4)});
    end
    led.EnableCount = 1'b0;
    repeat (40) begin
      tick();
      chk("hold_row5", {32'h0, led.GPIO_1[35:32]}, 36'd5);
    end
    led.EnableCount = 1'b1;
    repeat (3) tick();
    chk("reenable_still5", {32'h0, led.GPIO_1[35:32]}, 36'd5);
    tick();
    chk("reenable_row6", {32'h0, led.GPIO_1[35:32]}, 36'd6);

    // 4/5/6. Colour mix on row 3, live green update, blanking on first clock of a row.
    #2 reset = 1'b1;
    led.RedPixels[3] = 16'hFFFF;
    led.GrnPixels[3] = 16'h00FF;
    #2 reset = 1'b0;
    n = 0;
    repeat (13) tick();
    chk("mix_row3_first", led.GPIO_1, cols_at(n, 36'h3_00FF_FFFF));
    tick();
    chk("mix_row3", led.GPIO_1, 36'h3_00FF_FFFF);
    led.GrnPixels[3] = 16'hA5A5;
    tick();
    chk("live_update", led.GPIO_1, 36'h3_A5A5_FFFF);
    tick();
    chk("live_hold", led.GPIO_1, 36'h3_A5A5_FFFF);
    tick();
    chk("row4_first", led.GPIO_1, cols_at(n, 36'h4_0000_0010));
    tick();
    chk("row4_second", led.GPIO_1, 36'h4_0000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
